// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings and the
// fetch-unit sequencing state type.
package cpu_pkg;

  localparam int PC_WIDTH    = 10;
  localparam int INSTR_WIDTH = 32;

  localparam logic [5:0] OP_JUMP = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_NOP  = 6'b011001;
  localparam logic [5:0] OP_IN   = 6'b011010;
  localparam logic [5:0] OP_OUT  = 6'b011011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_EXECUTE    = 3'd1,
    ST_IO_WAIT    = 3'd2,
    ST_IO_RELEASE = 3'd3,
    ST_HALTED     = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: hold, absolute jump, PC-relative branch or sequential
// advance, all modulo 2^PC_WIDTH.
module pc_next #(
  parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
) (
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   hold,
  input  logic                   jump_sel,
  input  logic                   branch_sel,
  output logic [PC_WIDTH-1:0]    next_pc
);

  logic [PC_WIDTH-1:0] seq_pc_s;
  logic [PC_WIDTH-1:0] offset_s;
  logic                unused_s;

  // Upper instruction bits carry opcode/register fields this block ignores.
  assign unused_s = ^instr[INSTR_WIDTH-1:16];
  assign seq_pc_s = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign offset_s = PC_WIDTH'($signed(instr[15:0]));

  // Priority select of the next program counter.
  always_comb begin
    next_pc = seq_pc_s;
    if (hold) begin
      next_pc = pc;
    end else if (jump_sel) begin
      next_pc = instr[PC_WIDTH-1:0];
    end else if (branch_sel) begin
      next_pc = seq_pc_s + offset_s;
    end else begin
      next_pc = seq_pc_s;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing unit: two-cycle fetch/execute, blocking
// In/Out handshake with release wait, and a terminal halt.
module fetch_unit #(
  parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   halt,
  input  logic                   branch,
  input  logic                   jump,
  input  logic                   makeIO,
  input  logic                   branchCondition,
  input  logic                   ioAck,
  output logic [PC_WIDTH-1:0]    pcAddress,
  output logic [INSTR_WIDTH-1:0] instructionReg,
  output logic [5:0]             opcode,
  output logic                   commit,
  output logic                   ioRequest,
  output logic                   running
);

  import cpu_pkg::*;

  fetch_state_e           state_r, state_s;
  logic [PC_WIDTH-1:0]    pc_r, next_pc_s;
  logic [INSTR_WIDTH-1:0] ir_r;
  logic                   commit_r, io_request_r, running_r;
  logic                   ir_load_s, pc_load_s, commit_s;
  logic                   sel_hold_s, sel_jump_s, sel_branch_s;

  pc_next #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_pc_next (
    .pc         (pc_r),
    .instr      (ir_r),
    .hold       (sel_hold_s),
    .jump_sel   (sel_jump_s),
    .branch_sel (sel_branch_s),
    .next_pc    (next_pc_s)
  );

  // Next-state and retire decode; halt > makeIO > jump > taken branch.
  always_comb begin
    state_s      = state_r;
    ir_load_s    = 1'b0;
    pc_load_s    = 1'b0;
    commit_s     = 1'b0;
    sel_hold_s   = 1'b1;
    sel_jump_s   = 1'b0;
    sel_branch_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        ir_load_s = 1'b1;
        state_s   = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (halt) begin
          state_s = ST_HALTED;
        end else if (makeIO) begin
          state_s = ST_IO_WAIT;
        end else begin
          pc_load_s    = 1'b1;
          commit_s     = 1'b1;
          sel_hold_s   = 1'b0;
          sel_jump_s   = jump;
          sel_branch_s = branch & branchCondition;
          state_s      = ST_FETCH;
        end
      end
      ST_IO_WAIT: begin
        if (ioAck) begin
          pc_load_s  = 1'b1;
          commit_s   = 1'b1;
          sel_hold_s = 1'b0;
          state_s    = ST_IO_RELEASE;
        end else begin
          state_s = ST_IO_WAIT;
        end
      end
      ST_IO_RELEASE: begin
        // A held acknowledge must drop before the next fetch.
        if (ioAck) begin
          state_s = ST_IO_RELEASE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HALTED: state_s = ST_HALTED;
      default:   state_s = ST_FETCH;
    endcase
  end

  // State, PC, instruction latch and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_FETCH;
      pc_r         <= {PC_WIDTH{1'b0}};
      ir_r         <= {OP_NOP, {(INSTR_WIDTH-6){1'b0}}};
      commit_r     <= 1'b0;
      io_request_r <= 1'b0;
      running_r    <= 1'b1;
    end else begin
      state_r      <= state_s;
      if (pc_load_s) pc_r <= next_pc_s;
      if (ir_load_s) ir_r <= instruction;
      commit_r     <= commit_s;
      io_request_r <= (state_s == ST_IO_WAIT);
      running_r    <= (state_s != ST_HALTED);
    end
  end

  assign pcAddress      = pc_r;
  assign instructionReg = ir_r;
  assign opcode         = ir_r[INSTR_WIDTH-1 -: 6];
  assign commit         = commit_r;
  assign ioRequest      = io_request_r;
  assign running        = running_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random programs.
module tb_fetch_unit;

  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction;
  logic        halt, branch, jump, makeIO, branchCondition;
  logic        ioAck = 1'b0;
  logic [9:0]  pcAddress;
  logic [31:0] instructionReg;
  logic [5:0]  opcode;
  logic        commit, ioRequest, running;

  fetch_unit dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .halt(halt), .branch(branch), .jump(jump), .makeIO(makeIO),
    .branchCondition(branchCondition), .ioAck(ioAck),
    .pcAddress(pcAddress), .instructionReg(instructionReg), .opcode(opcode),
    .commit(commit), .ioRequest(ioRequest), .running(running)
  );

  always #5 clock = ~clock;

  // Clocked ROM: data for the presented address is ready before the next rising edge.
  logic [31:0] rom [0:1023];
  always @(negedge clock) instruction <= rom[pcAddress];

  // Decoder stand-in, with optional random overlapping flags to exercise priority.
  logic       noise_en = 1'b0, noise_jump = 1'b0, noise_branch = 1'b0, bc_rand = 1'b0;
  logic [1:0] bc_mode = 2'd0;
  logic [5:0] dec_op;
  assign dec_op          = instructionReg[31:26];
  assign halt            = (dec_op == OP_HALT);
  assign makeIO          = (dec_op == OP_IN) || (dec_op == OP_OUT);
  assign jump            = (dec_op == OP_JUMP) || noise_jump;
  assign branch          = (dec_op == OP_BEQ) || (dec_op == OP_BNE) || noise_branch;
  assign branchCondition = (bc_mode == 2'd1) ? 1'b1 : (bc_mode == 2'd2) ? 1'b0 : bc_rand;

  int n_checks = 0;
  int n_pass   = 0;
  int commit_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clock) if (reset === 1'b1 && commit === 1'b1) commit_total <= commit_total + 1;

  // ---------------- reference model (instruction-level) ----------------
  logic [9:0]  exp_pc = 10'd0;
  logic [31:0] exp_ir = {OP_NOP, 26'd0};
  logic        exp_commit = 1'b0, exp_ioreq = 1'b0, exp_running = 1'b1;
  logic        abort = 1'b1;

  always @(negedge reset) begin
    abort       = 1'b1;
    exp_pc      = 10'd0;
    exp_ir      = {OP_NOP, 26'd0};
    exp_commit  = 1'b0;
    exp_ioreq   = 1'b0;
    exp_running = 1'b1;
  end

  task automatic model_run();
    int tgt;
    forever begin
      @(posedge clock); if (abort) return;
      exp_ir     = rom[exp_pc];
      exp_commit = 1'b0;
      @(posedge clock); if (abort) return;
      if (halt) begin
        exp_running = 1'b0;
        forever begin @(posedge clock); if (abort) return; end
      end else if (makeIO) begin
        exp_ioreq = 1'b1;
        do begin @(posedge clock); if (abort) return; end while (!ioAck);
        exp_ioreq  = 1'b0;
        exp_commit = 1'b1;
        exp_pc     = exp_pc + 10'd1;
        do begin @(posedge clock); if (abort) return; exp_commit = 1'b0; end while (ioAck);
      end else begin
        exp_commit = 1'b1;
        if (jump) tgt = int'(exp_ir[9:0]);
        else if (branch && branchCondition) tgt = int'(exp_pc) + 1 + int'($signed(exp_ir[15:0]));
        else tgt = int'(exp_pc) + 1;
        exp_pc = 10'(tgt % 1024 + 1024);
      end
    end
  endtask

  initial begin
    forever begin
      wait (reset === 1'b1);
      abort = 1'b0;
      model_run();
      wait (reset === 1'b0);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    check("pcAddress", 32'(pcAddress), 32'(exp_pc));
    check("instructionReg", instructionReg, exp_ir);
    check("opcode", 32'(opcode), 32'(exp_ir[31:26]));
    check("commit", 32'(commit), 32'(exp_commit));
    check("ioRequest", 32'(ioRequest), 32'(exp_ioreq));
    check("running", 32'(running), 32'(exp_running));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clock); #1;
    if (noise_en) begin
      noise_jump   = ($urandom_range(0, 7) == 0);
      noise_branch = ($urandom_range(0, 3) == 0);
      bc_rand      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ioAck = ~ioAck;
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 1024; i++) rom[i] = {OP_NOP, 26'd0};
  endtask

  task automatic release_reset(output int base);
    step(); step();
    reset = 1'b1;
    base  = commit_total;
  endtask

  int base;
  logic [31:0] r;

  initial begin
    fill_nop();
    #1 reset = 1'b0;

    // Nop stream: one instruction per two cycles.
    release_reset(base);
    repeat (20) step();
    check("nop_pc_after_20", 32'(pcAddress), 32'd10);
    check("nop_commits_20", 32'(commit_total - base), 32'd10);
    check("nop_opcode", 32'(opcode), 32'(6'b011001));

    // Jump at 5 to 0x020.
    reset = 1'b0; fill_nop(); rom[5] = {OP_JUMP, 26'h020};
    release_reset(base);
    repeat (11) step();
    check("jump_latched", 32'(opcode), 32'(OP_JUMP));
    check("jump_commits_before", 32'(commit_total - base), 32'd5);
    step();
    check("jump_target", 32'(pcAddress), 32'h020);
    check("jump_one_commit", 32'(commit_total - base), 32'd6);

    // Branch at 10, offset -4: taken lands on 7, not taken on 11.
    reset = 1'b0; fill_nop(); rom[10] = {OP_BEQ, 10'd0, 16'hFFFC}; bc_mode = 2'd1;
    release_reset(base);
    repeat (22) step();
    check("branch_taken_pc", 32'(pcAddress), 32'd7);
    reset = 1'b0; bc_mode = 2'd2;
    release_reset(base);
    repeat (22) step();
    check("branch_not_taken_pc", 32'(pcAddress), 32'd11);
    bc_mode = 2'd0;

    // In at 3: waits for ack, one commit per held press, fetch after release.
    reset = 1'b0; fill_nop(); rom[3] = {OP_IN, 26'd0}; ioAck = 1'b0;
    release_reset(base);
    repeat (8) step();
    check("io_request_high", 32'(ioRequest), 32'd1);
    repeat (20) step();
    check("io_wait_pc", 32'(pcAddress), 32'd3);
    check("io_wait_no_commit", 32'(commit_total - base), 32'd3);
    ioAck = 1'b1;
    repeat (5) step();
    check("io_single_commit", 32'(commit_total - base), 32'd4);
    check("io_pc_advanced", 32'(pcAddress), 32'd4);
    check("io_request_dropped", 32'(ioRequest), 32'd0);
    check("io_held_no_fetch", 32'(opcode), 32'(OP_IN));
    ioAck = 1'b0;
    step(); step();
    check("io_next_fetched", 32'(opcode), 32'(OP_NOP));

    // Halt at 8: frozen until reset.
    reset = 1'b0; fill_nop(); rom[8] = {OP_HALT, 26'd0};
    release_reset(base);
    repeat (18) step();
    check("halt_running_low", 32'(running), 32'd0);
    repeat (50) step();
    check("halt_pc_frozen", 32'(pcAddress), 32'd8);
    check("halt_no_commit", 32'(commit_total - base), 32'd8);
    reset = 1'b0; #1;
    check("halt_reset_pc", 32'(pcAddress), 32'd0);
    check("halt_reset_running", 32'(running), 32'd1);

    // Wrap from 1023 to 0.
    fill_nop(); rom[0] = {OP_JUMP, 26'h3FF};
    release_reset(base);
    repeat (2) step();
    check("wrap_at_1023", 32'(pcAddress), 32'd1023);
    repeat (2) step();
    check("wrap_to_0", 32'(pcAddress), 32'd0);

    // Reset during IO_WAIT aborts without commit.
    reset = 1'b0; fill_nop(); rom[0] = {OP_OUT, 26'd0}; ioAck = 1'b0;
    release_reset(base);
    repeat (2) step();
    check("abort_io_request", 32'(ioRequest), 32'd1);
    reset = 1'b0; #1;
    check("abort_io_dropped", 32'(ioRequest), 32'd0);
    check("abort_no_commit", 32'(commit), 32'd0);
    step();
    check("abort_commit_count", 32'(commit_total - base), 32'd0);

    // Random programs with overlapping decode flags and random acknowledges.
    for (int i = 0; i < 1024; i++) begin
      r = $urandom();
      case ($urandom_range(0, 15))
        6, 7, 8: rom[i] = {OP_BEQ, r[25:0]};
        9:       rom[i] = {OP_BNE, r[25:0]};
        10, 11:  rom[i] = {OP_JUMP, r[25:0]};
        12:      rom[i] = {OP_IN, r[25:0]};
        13:      rom[i] = {OP_OUT, r[25:0]};
        default: rom[i] = {OP_NOP, r[25:0]};
      endcase
    end
    noise_en = 1'b1;
    release_reset(base);
    for (int c = 0; c < 3000; c++) begin
      if (c == 1000 || c == 2000) begin
        reset = 1'b0;
        release_reset(base);
      end
      step();
    end
    noise_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
